mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: N-port arbiter onto a single-outstanding memory interface.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module mem_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    localparam int BE_W     = DATA_W / 8,
    localparam int IDX_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]   req_byte_enable,
    output logic [NUM_PORTS-1:0]        req_resp,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [BE_W-1:0]             mem_byte_enable,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_resp,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic                 mem_read_q, mem_write_q;
    logic [ADDR_W-1:0]    mem_address_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [BE_W-1:0]      mem_be_q;
    logic [IDX_W-1:0]     grant_idx_q;

    logic [NUM_PORTS-1:0] w_req;
    logic [IDX_W-1:0]     w_win;
    logic [IDX_W-1:0]     w_win_lo;
    logic                 w_rd, w_wr;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic [BE_W-1:0]      w_be;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     w_win_hi;
    logic                 w_found_hi;
`endif

    assign w_req = req_read | req_write;

    // Downward scans leave the lowest qualifying index as the final assignment.
    always_comb begin
        w_win_lo = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i]) w_win_lo = IDX_W'(i);
        end
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        w_win_hi   = '0;
        w_found_hi = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (w_req[i] && (IDX_W'(i) > ptr_q)) begin
                w_win_hi   = IDX_W'(i);
                w_found_hi = 1'b1;
            end
        end
        w_win = w_found_hi ? w_win_hi : w_win_lo;
`else
        w_win = w_win_lo;
`endif
    end

    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_be    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_win == IDX_W'(i)) begin
                w_rd    = req_read[i];
                w_wr    = req_write[i];
                w_addr  = req_address[i*ADDR_W +: ADDR_W];
                w_wdata = req_wdata[i*DATA_W +: DATA_W];
                w_be    = req_byte_enable[i*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (|w_req) state_d = S_BUSY;
        end else if (mem_resp) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            grant_idx_q   <= '0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            ptr_q         <= IDX_W'(NUM_PORTS - 1);
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                if (|w_req) begin
                    // Write takes precedence when a port raises both strobes.
                    mem_read_q    <= w_rd & ~w_wr;
                    mem_write_q   <= w_wr;
                    mem_address_q <= w_addr;
                    mem_wdata_q   <= w_wdata;
                    mem_be_q      <= w_be;
                    grant_idx_q   <= w_win;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    ptr_q         <= w_win;
`endif
                end
            end else if (mem_resp) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

    always_comb begin
        req_resp = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_resp[i] = (state_q == S_BUSY) && mem_resp && !rst && (grant_idx_q == IDX_W'(i));
        end
    end

    assign req_rdata       = mem_rdata;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_byte_enable = mem_be_q;
    assign grant_valid     = (state_q == S_BUSY);
    assign grant_idx       = grant_idx_q;

endmodule
`default_nettype wire
